// File: rtl/cossin_arbiter.sv
// Three-slot round-robin arbiter that shares one CORDIC cos/sin engine.
// The engine is reset and the operation is reported with err=1 if it does
// not answer within TIMEOUT wait cycles.
//
// Handshake: req[k] is a level held from request until the cycle after
// done[k] pulses. Only IDLE samples req, and beta_in is captured once, at
// grant time. cossin_start is a one-cycle strobe. cossin_done is honoured
// only in WAIT, and cossin_cos/cossin_sin are taken in that same cycle.
module cossin_arbiter #(
  parameter int N       = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     req,
  input  logic [3*N-1:0] beta_in,
  output logic [2:0]     gnt,
  output logic [2:0]     done,
  output logic           err,
  output logic [N-1:0]   cos_out,
  output logic [N-1:0]   sin_out,
  output logic           busy,
  output logic           cossin_start,
  output logic [N-1:0]   cossin_beta,
  input  logic           cossin_done,
  input  logic [N-1:0]   cossin_cos,
  input  logic [N-1:0]   cossin_sin,
  output logic           cossin_rst_n,
  output logic [2:0]     dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_RECOVER = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam logic [12:0] TIMER_LAST = 13'(TIMEOUT - 1);
  localparam logic [12:0] TIMER_SAT  = 13'h1fff;

  state_t       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [2:0]   gnt_q, gnt_d;
  logic         err_q, err_d;
  logic [N-1:0] cos_q, cos_d;
  logic [N-1:0] sin_q, sin_d;
  logic [N-1:0] beta_q, beta_d;
  logic [12:0]  timer_q, timer_d;
  logic         rec_q, rec_d;
  logic         rst_n_q, rst_n_d;

  logic         pick_valid;
  logic [1:0]   pick_idx;
  logic [2:0]   cand;
  logic [N-1:0] pick_beta;

  // Round-robin search: offsets 2,1,0 are visited so the nearest one to ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    cand       = 3'd0;
    for (int i = 2; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (req[cand[1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[1:0];
      end
    end
  end

  // Angle of the slot being granted.
  always_comb begin
    case (pick_idx)
      2'd1:    pick_beta = beta_in[2*N-1:N];
      2'd2:    pick_beta = beta_in[3*N-1:2*N];
      default: pick_beta = beta_in[N-1:0];
    endcase
  end

  // Next-state logic for the arbitration / CORDIC supervision FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    beta_d  = beta_q;
    timer_d = timer_q;
    rec_d   = rec_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          gnt_d   = 3'b001 << pick_idx;
          beta_d  = pick_beta;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = 13'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving in the last timer cycle still counts as success.
        if (cossin_done) begin
          cos_d   = cossin_cos;
          sin_d   = cossin_sin;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timer_q == TIMER_LAST) begin
          rec_d   = 1'b0;
          state_d = S_RECOVER;
        end else if (timer_q != TIMER_SAT) begin
          timer_d = timer_q + 13'd1;
        end
      end
      S_RECOVER: begin
        cos_d = '0;
        sin_d = '0;
        err_d = 1'b1;
        if (rec_q) state_d = S_RESP;
        else       rec_d   = 1'b1;
      end
      S_RESP: begin
        case (gnt_q)
          3'b010:  ptr_d = 2'd2;
          3'b100:  ptr_d = 2'd0;
          default: ptr_d = 2'd1;
        endcase
        gnt_d   = 3'b000;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Engine reset is held low for exactly the cycles spent in RECOVER.
    rst_n_d = (state_d != S_RECOVER);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 3'b000;
      err_q   <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
      beta_q  <= '0;
      timer_q <= 13'd0;
      rec_q   <= 1'b0;
      rst_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      beta_q  <= beta_d;
      timer_q <= timer_d;
      rec_q   <= rec_d;
      rst_n_q <= rst_n_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = (state_q == S_RESP) ? gnt_q : 3'b000;
  assign err          = err_q;
  assign cos_out      = cos_q;
  assign sin_out      = sin_q;
  assign busy         = (state_q != S_IDLE);
  assign cossin_start = (state_q == S_ISSUE);
  assign cossin_beta  = beta_q;
  assign cossin_rst_n = rst_n_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_cossin_arbiter.sv
// Bench for cossin_arbiter: the bench plays the CORDIC engine and the
// requesters, and predicts grants and results from round-robin rules.
module tb_cossin_arbiter;
  localparam int N       = 32;
  localparam int TIMEOUT = 4096;

  logic           clk;
  logic           rst;
  logic [2:0]     req;
  logic [3*N-1:0] beta_in;
  logic [2:0]     gnt;
  logic [2:0]     done;
  logic           err;
  logic [N-1:0]   cos_out;
  logic [N-1:0]   sin_out;
  logic           busy;
  logic           cossin_start;
  logic [N-1:0]   cossin_beta;
  logic           cossin_done;
  logic [N-1:0]   cossin_cos;
  logic [N-1:0]   cossin_sin;
  logic           cossin_rst_n;
  logic [2:0]     dbg_state_o;

  cossin_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .beta_in      (beta_in),
    .gnt          (gnt),
    .done         (done),
    .err          (err),
    .cos_out      (cos_out),
    .sin_out      (sin_out),
    .busy         (busy),
    .cossin_start (cossin_start),
    .cossin_beta  (cossin_beta),
    .cossin_done  (cossin_done),
    .cossin_cos   (cossin_cos),
    .cossin_sin   (cossin_sin),
    .cossin_rst_n (cossin_rst_n),
    .dbg_state_o  (dbg_state_o)
  );

  // Clock and run-time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference state: round-robin pointer, last reported results, and
  // the queue of results the engine has been told to return.
  int           ptr_m = 0;
  logic [N-1:0] cos_m = '0;
  logic [N-1:0] sin_m = '0;
  logic         err_m = 1'b0;
  logic [2*N-1:0] exp_q[$];

  initial begin
    #2_000_000;
    nerr++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input int p, input logic [2:0] r);
    for (int i = 0; i < 3; i++) begin
      if (r[(p + i) % 3]) return (p + i) % 3;
    end
    return -1;
  endfunction

  // One full grant-to-idle transaction. lat >= 0: engine answers in the
  // lat-th WAIT cycle with (c, s). lat < 0: the engine never answers.
  task automatic do_op(input int lat, input logic [N-1:0] c, input logic [N-1:0] s);
    int             slot;
    logic [2:0]     oh;
    logic [2*N-1:0] e;
    logic [N-1:0]   b;
    slot = pick(ptr_m, req);
    oh   = 3'b001 << slot;
    b    = beta_in[slot*N +: N];
    step();
    nvec++;
    if (gnt !== oh || cossin_start !== 1'b1 || busy !== 1'b1)
      begin nerr++; $display("FAIL issue: gnt=%b start=%b busy=%b, want gnt=%b start=1 busy=1", gnt, cossin_start, busy, oh); end
    nvec++;
    if (cossin_beta !== b)
      begin nerr++; $display("FAIL beta: got %h want %h", cossin_beta, b); end
    step();
    nvec++;
    if (cossin_start !== 1'b0 || gnt !== oh)
      begin nerr++; $display("FAIL start_once: start=%b gnt=%b, want start=0 gnt=%b", cossin_start, gnt, oh); end
    if (lat >= 0) begin
      exp_q.push_back({c, s});
      repeat (lat) step();
      nvec++;
      if (done !== 3'b000 || cossin_rst_n !== 1'b1 || busy !== 1'b1)
        begin nerr++; $display("FAIL wait: done=%b rst_n=%b busy=%b, want 000 1 1", done, cossin_rst_n, busy); end
      cossin_done = 1'b1;
      cossin_cos  = c;
      cossin_sin  = s;
      step();
      cossin_done = 1'b0;
      cossin_cos  = $urandom;
      cossin_sin  = $urandom;
      err_m = 1'b0;
    end else begin
      exp_q.push_back('0);
      repeat (TIMEOUT - 1) step();
      nvec++;
      if (cossin_rst_n !== 1'b1 || done !== 3'b000)
        begin nerr++; $display("FAIL last_wait: rst_n=%b done=%b, want 1 000", cossin_rst_n, done); end
      step();
      nvec++;
      if (cossin_rst_n !== 1'b0)
        begin nerr++; $display("FAIL recover1: rst_n=%b want 0", cossin_rst_n); end
      step();
      nvec++;
      if (cossin_rst_n !== 1'b0 || done !== 3'b000)
        begin nerr++; $display("FAIL recover2: rst_n=%b done=%b, want 0 000", cossin_rst_n, done); end
      step();
      err_m = 1'b1;
    end
    e = exp_q.pop_front();
    cos_m = e[2*N-1:N];
    sin_m = e[N-1:0];
    nvec++;
    if (done !== oh || err !== err_m || cossin_rst_n !== 1'b1)
      begin nerr++; $display("FAIL resp: done=%b err=%b rst_n=%b, want %b %b 1", done, err, cossin_rst_n, oh, err_m); end
    nvec++;
    if (cos_out !== cos_m || sin_out !== sin_m)
      begin nerr++; $display("FAIL result: cos=%h sin=%h, want %h %h", cos_out, sin_out, cos_m, sin_m); end
    ptr_m = (slot + 1) % 3;
    step();
    nvec++;
    if (done !== 3'b000 || gnt !== 3'b000 || busy !== 1'b0)
      begin nerr++; $display("FAIL idle: done=%b gnt=%b busy=%b, want 000 000 0", done, gnt, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 3'b111;
    beta_in = {$urandom, $urandom, $urandom};
    cossin_done = 1'b1;
    cossin_cos = $urandom;
    cossin_sin = $urandom;
    repeat (3) step();
    nvec++;
    if (gnt !== 3'b000 || done !== 3'b000 || err !== 1'b0 || busy !== 1'b0 || cossin_start !== 1'b0 || cossin_rst_n !== 1'b0)
      begin nerr++; $display("FAIL reset_ctl: gnt=%b done=%b err=%b busy=%b start=%b rst_n=%b", gnt, done, err, busy, cossin_start, cossin_rst_n); end
    nvec++;
    if (cos_out !== '0 || sin_out !== '0 || cossin_beta !== '0)
      begin nerr++; $display("FAIL reset_data: cos=%h sin=%h beta=%h, want 0", cos_out, sin_out, cossin_beta); end
    req = 3'b000;
    cossin_done = 1'b0;
    rst = 1'b0;
    step();
    nvec++;
    if (cossin_rst_n !== 1'b1 || busy !== 1'b0 || gnt !== 3'b000)
      begin nerr++; $display("FAIL reset_exit: rst_n=%b busy=%b gnt=%b, want 1 0 000", cossin_rst_n, busy, gnt); end
    ptr_m = 0;
    cos_m = '0;
    sin_m = '0;
  endtask

  task automatic test_contention();
    req = 3'b111;
    beta_in = {$urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) do_op($urandom_range(0, 12), $urandom, $urandom);
    req = 3'b000;
  endtask

  task automatic test_single();
    req = 3'b001;
    beta_in = {$urandom, $urandom, 32'h0000_0000};
    do_op(10, 32'h0001_0000, 32'h0000_0000);
    req = 3'b000;
  endtask

  task automatic test_timeout();
    req = 3'b010;
    beta_in = {$urandom, $urandom, $urandom};
    do_op(-1, '0, '0);
    req = 3'b100;
    do_op(7, $urandom, $urandom);
    req = 3'b000;
  endtask

  task automatic test_tie();
    req = 3'b001;
    beta_in = {$urandom, $urandom, $urandom};
    do_op(TIMEOUT - 1, $urandom, $urandom);
    req = 3'b000;
  endtask

  task automatic test_mid_reset();
    ptr_m = 0;
    req = 3'b100;
    beta_in = {$urandom, $urandom, $urandom};
    step();
    nvec++;
    if (gnt !== 3'b100)
      begin nerr++; $display("FAIL mid_grant: gnt=%b want 100", gnt); end
    repeat (4) step();
    rst = 1'b1;
    step();
    nvec++;
    if (gnt !== 3'b000 || done !== 3'b000 || err !== 1'b0 || busy !== 1'b0 || cossin_rst_n !== 1'b0 || cos_out !== '0 || cossin_beta !== '0)
      begin nerr++; $display("FAIL mid_reset: gnt=%b done=%b err=%b busy=%b rst_n=%b cos=%h beta=%h", gnt, done, err, busy, cossin_rst_n, cos_out, cossin_beta); end
    ptr_m = 0;
    cos_m = '0;
    sin_m = '0;
    exp_q.delete();
    req = 3'b110;
    rst = 1'b0;
    do_op(5, $urandom, $urandom);
    req = 3'b000;
  endtask

  task automatic test_stray();
    cossin_done = 1'b1;
    cossin_cos = $urandom;
    cossin_sin = $urandom;
    step();
    cossin_done = 1'b0;
    step();
    nvec++;
    if (done !== 3'b000 || busy !== 1'b0 || cos_out !== cos_m || sin_out !== sin_m)
      begin nerr++; $display("FAIL stray: done=%b busy=%b cos=%h sin=%h, want 000 0 %h %h", done, busy, cos_out, sin_out, cos_m, sin_m); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      req = 3'($urandom_range(1, 7));
      beta_in = {$urandom, $urandom, $urandom};
      do_op($urandom_range(0, 15), $urandom, $urandom);
    end
    req = 3'b000;
  endtask

  initial begin
    rst = 1'b1;
    req = 3'b000;
    beta_in = '0;
    cossin_done = 1'b0;
    cossin_cos = '0;
    cossin_sin = '0;
    test_reset();
    test_contention();
    test_single();
    test_timeout();
    test_tie();
    test_stray();
    test_mid_reset();
    test_stray();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cossin_arbiter.md
COSSIN_ARBITER -- requirements
Module: cossin_arbiter

Interface
REQ-001 Parameter: N, 32, datapath width; Q16 fixed point, sign-magnitude (bit N-1 is the sign, 15 integer bits, 16 fraction bits).
REQ-002 Parameter: TIMEOUT, 4096, maximum number of WAIT cycles before a CORDIC operation is aborted.
REQ-003 Port: clk  in  1  single clock; all logic on the rising edge.
REQ-004 Port: rst  in  1  reset, synchronous and active-high.
REQ-005 Port: req  in  3  request per slot, level, held until that slot's done pulse.
REQ-006 Port: beta_in  in  3*N  angle per slot; slot k occupies bits [N*k+N-1 : N*k]; stable while req[k]=1.
REQ-007 Port: gnt  out  3  one-hot grant; all zero when idle.
REQ-008 Port: done  out  3  one-cycle completion pulse per slot.
REQ-009 Port: err  out  1  valid with done; 1 means the operation timed out.
REQ-010 Port: cos_out, sin_out  out  N each  result registers; hold their value until the next completion.
REQ-011 Port: busy  out  1  high in every state except IDLE.
REQ-012 Port: cossin_start  out  1  start strobe to the shared CORDIC engine.
REQ-013 Port: cossin_beta  out  N  latched angle to the CORDIC engine.
REQ-014 Port: cossin_done  in  1  one-cycle done pulse from the CORDIC engine.
REQ-015 Port: cossin_cos, cossin_sin  in  N each  CORDIC results, valid in the cycle cossin_done=1.
REQ-016 Port: cossin_rst_n  out  1  active-low reset to the CORDIC engine.

Function
REQ-017 States: IDLE, ISSUE, WAIT, RECOVER, RESP; every output is a registered or state-decoded signal, with no combinational path from any input to any output.
REQ-018 IDLE with any req set: grant one slot by round-robin (search order ptr, ptr+1, ptr+2 mod 3), set gnt, latch that slot's beta into cossin_beta, go to ISSUE; with no req set, stay in IDLE.
REQ-019 ISSUE: cossin_start=1 for exactly this one cycle; clear the timer; go to WAIT.
REQ-020 WAIT, cossin_done=1: capture cossin_cos/cossin_sin into cos_out/sin_out, set err=0, go to RESP.
REQ-021 WAIT, cossin_done=0: increment the timer; when the timer reaches TIMEOUT-1, go to RECOVER.
REQ-022 If cossin_done=1 and timer=TIMEOUT-1 occur in the same cycle, the done event wins: normal capture, err=0.
REQ-023 RECOVER: cossin_rst_n=0 for exactly 2 cycles; set cos_out=sin_out=0 and err=1; then go to RESP.
REQ-024 RESP: done[g]=1 for this single cycle, where g is the granted slot; set ptr to (g+1) mod 3; clear gnt at the exit edge; go to IDLE.
REQ-025 A requester deasserts req on the edge that ends its done cycle; IDLE is the only state that samples req.
REQ-026 If req[g] drops during ISSUE, WAIT or RECOVER, the operation still completes and done[g] still pulses; beta is never re-sampled.
REQ-027 cossin_done outside WAIT is ignored and changes no state or output.
REQ-028 Latency: req seen in IDLE at edge 0 gives gnt=1 and cossin_start=1 at edge 1 and WAIT at edge 2; done[g] is high in the cycle after the CORDIC done is sampled.
REQ-029 Timer width is 13 bits; the timer saturates and does not wrap.
REQ-030 Minimum cycles between consecutive grants = CORDIC latency + 4.

Reset
REQ-031 While rst=1, on each edge: state=IDLE, ptr=0, gnt=0, done=0, err=0, cos_out=0, sin_out=0, busy=0, cossin_start=0, cossin_beta=0, timer=0, cossin_rst_n=0.
REQ-032 cossin_rst_n goes to 1 on the first edge with rst=0.
REQ-033 rst asserted in any state aborts the operation with no done pulse.

Verification
REQ-034 Single request: req=001, beta slot0=0x00000000, model returns done after 10 cycles with cos=0x00010000, sin=0 -> exactly one cossin_start pulse, cossin_beta=0, done=001 for 1 cycle, err=0, cos_out=0x00010000.
REQ-035 Contention: req=111 held, requests re-raised after each done -> grant order 0,1,2,0; each cossin_beta matches the granted slot's beta_in.
REQ-036 Timeout: model never asserts done -> after TIMEOUT WAIT cycles, cossin_rst_n=0 for 2 cycles, then done[g]=1, err=1, cos_out=sin_out=0; the next request completes normally.
REQ-037 Tie: cossin_done asserted in the timeout cycle -> err=0, results captured, no RECOVER.
REQ-038 rst pulsed mid-WAIT with slot 2 granted -> all outputs at reset values, no done; a subsequent req=110 grants slot 1.
REQ-039 Stray cossin_done pulse in IDLE -> no done, cos_out/sin_out unchanged.
